// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUop encodings, serial sequencer FSM states and default width.
package alu_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_NAND = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_ADDU = 4'b1010;
  localparam logic [3:0] OP_SUBU = 4'b1110;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCalc  = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } state_e;

  function automatic logic is_arith(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_SLT, OP_ADDU, OP_SUBU, OP_SLTU};
  endfunction

endpackage

// File: rtl/alu_serial_bit.sv
// Combinational one-bit ALU slice: logic ops and full-adder sum/carry for the serial sequencer.
module alu_serial_bit
  import alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       carry_in,
  input  logic [3:0] alu_op,
  output logic       res_i,
  output logic       carry_out
);

  logic b_eff;
  logic sum;

  // alu_op[2] selects subtraction (b inverted, carry preloaded with 1) for arithmetic ops.
  assign b_eff = b_i ^ alu_op[2];
  assign sum   = a_i ^ b_eff ^ carry_in;

  always_comb begin
    res_i     = 1'b0;
    carry_out = 1'b0;
    case (alu_op)
      OP_AND:  res_i = a_i & b_i;
      OP_OR:   res_i = a_i | b_i;
      OP_NAND: res_i = ~(a_i & b_i);
      OP_NOR:  res_i = ~(a_i | b_i);
      OP_ADD, OP_SUB, OP_SLT, OP_ADDU, OP_SUBU, OP_SLTU: begin
        res_i     = sum;
        carry_out = (a_i & b_eff) | (carry_in & (a_i ^ b_eff));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu32_serial_seq.sv
// Bit-serial 32-bit ALU sequencer, one bit per clock LSB first, start/busy/done handshake.
// Define ALU_SEQ_SHIFT_EN to enable the SLL/SRL shift state; otherwise shifts return all-ones.
module alu32_serial_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             v,
  output logic             set,
  output logic             zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             v_q, v_d, set_q, set_d, zero_q, zero_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             accept;
  logic             bit_res, bit_cout;
  logic             f_v, f_set;

  assign accept = (state_q == StIdle) && start;

  alu_serial_bit u_bit (
    .a_i       (a_q[cnt_q]),
    .b_i       (b_q[cnt_q]),
    .carry_in  (carry_q),
    .alu_op    (op_q),
    .res_i     (bit_res),
    .carry_out (bit_cout)
  );

  // On the MSB edge carry_q is the carry into the MSB.
  assign f_v   = op_q[3] ? bit_cout : (bit_cout ^ carry_q);
  assign f_set = op_q[3] ? ~bit_cout : (f_v ^ bit_res);

`ifdef ALU_SEQ_SHIFT_EN
  logic [SHAMT_W-1:0] amt_q, amt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amt_q <= '0;
    end else begin
      amt_q <= amt_d;
    end
  end
`else
  logic [SHAMT_W-1:0] unused_shamt;
  assign unused_shamt = b[SHAMT_W-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    v_d      = v_q;
    set_d    = set_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef ALU_SEQ_SHIFT_EN
    amt_d    = amt_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          busy_d  = 1'b1;
          cnt_d   = '0;
          carry_d = alu_op[2];
          v_d     = 1'b0;
          set_d   = 1'b0;
          zero_d  = 1'b0;
          if (alu_op == OP_SLL || alu_op == OP_SRL) begin
`ifdef ALU_SEQ_SHIFT_EN
            result_d = a;
            amt_d    = b[SHAMT_W-1:0];
            if (b[SHAMT_W-1:0] == '0) begin
              state_d = StDone;
              done_d  = 1'b1;
              zero_d  = (a == '0);
            end else begin
              state_d = StShift;
            end
`else
            result_d = '1;
            state_d  = StDone;
            done_d   = 1'b1;
`endif
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        carry_d  = bit_cout;
        result_d = {bit_res, result_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          if (is_arith(op_q)) begin
            v_d   = f_v;
            set_d = f_set;
          end
          if (op_q == OP_SLT || op_q == OP_SLTU) begin
            result_d = {{(WIDTH - 1){1'b0}}, f_set};
          end
          zero_d  = (result_d == '0);
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
`ifdef ALU_SEQ_SHIFT_EN
      StShift: begin
        result_d = (op_q == OP_SLL) ? (result_q << 1) : (result_q >> 1);
        amt_d    = amt_q - SHAMT_W'(1);
        if (amt_q == SHAMT_W'(1)) begin
          zero_d  = (result_d == '0);
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
`endif
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      v_q      <= 1'b0;
      set_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      v_q      <= v_d;
      set_q    <= set_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      if (accept) begin
        op_q <= alu_op;
        a_q  <= a;
        b_q  <= b;
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign v      = v_q;
  assign set    = set_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu32_serial_seq.sv
// Self-checking bench for alu32_serial_seq: directed and random ops against an arithmetic model.
module tb_alu32_serial_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  alu_op = 4'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, v, set, zero;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  localparam int TIMEOUT = 100;

  alu32_serial_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .alu_op (alu_op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .v      (v),
    .set    (set),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Reference: results and flags derived from integer arithmetic on the operands.
  function automatic void model(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                                output logic [31:0] r, output logic mv, output logic ms,
                                output logic mz, output int lat);
    longint sa, sb, s;
    logic [63:0] u;
    sa  = longint'($signed(aa));
    sb  = longint'($signed(bb));
    lat = 32;
    mv  = 1'b0;
    ms  = 1'b0;
    r   = '0;
    case (op)
      4'b0000: r = aa & bb;
      4'b0001: r = aa | bb;
      4'b0100: r = ~(aa & bb);
      4'b0101: r = ~(aa | bb);
      4'b0010: begin
        s = sa + sb; r = aa + bb;
        mv = (s != longint'($signed(r))); ms = (s < 0);
      end
      4'b0110, 4'b0111: begin
        s = sa - sb; r = aa - bb;
        mv = (s != longint'($signed(r))); ms = (s < 0);
        if (op == 4'b0111) r = {31'b0, ms};
      end
      4'b1010: begin
        u = {32'b0, aa} + {32'b0, bb}; r = aa + bb;
        mv = (u >= 64'h1_0000_0000); ms = ~mv;
      end
      4'b1110, 4'b1111: begin
        r = aa - bb; mv = (aa >= bb); ms = (aa < bb);
        if (op == 4'b1111) r = {31'b0, ms};
      end
`ifdef ALU_SEQ_SHIFT_EN
      4'b1000: begin r = aa << bb[4:0]; lat = int'(bb[4:0]); end
      4'b1001: begin r = aa >> bb[4:0]; lat = int'(bb[4:0]); end
`else
      4'b1000, 4'b1001: begin r = 32'hFFFF_FFFF; lat = 0; end
`endif
      default: r = '0;
    endcase
    mz = (r == '0);
  endfunction

  // Issues one op once idle; lat counts edges from accept to the first cycle with done high.
  task automatic run_op(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                        output logic [31:0] r, output logic ov, output logic os,
                        output logic oz, output int lat);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < TIMEOUT) begin
      @(negedge clk);
      guard++;
    end
    alu_op = op; a = aa; b = bb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = result; ov = v; os = set; oz = zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset result: got %h expected 0", result); end
    checks++; if ({v, set, zero} !== 3'b000) begin
      errors++; $display("FAIL reset flags: got v/set/zero %b expected 000", {v, set, zero});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [3:0]  ops[14] = '{4'b0010, 4'b0110, 4'b0111, 4'b1111, 4'b1110, 4'b1000, 4'b1001,
                             4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b1010, 4'b0011, 4'b1000};
    logic [31:0] as[14] = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd1, 32'd3, 32'd1,
                            32'hDEAD_BEEF, 32'hF0F0_1234, 32'h0F00_0001, 32'hFFFF_0000,
                            32'h0000_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000};
    logic [31:0] bs[14] = '{32'd1, 32'd5, 32'd1, 32'hFFFF_FFFF, 32'd2, 32'd4, 32'd0,
                            32'h0FF0_FFFF, 32'h00F0_0010, 32'hFF00_FF00, 32'h00FF_0000,
                            32'd1, 32'h9ABC_DEF0, 32'd31};
    logic [31:0] r, er;
    logic ov, os, oz, ev, es, ez;
    int lat, el;
    for (int i = 0; i < 14; i++) begin
      model(ops[i], as[i], bs[i], er, ev, es, ez, el);
      run_op(ops[i], as[i], bs[i], r, ov, os, oz, lat);
      checks++; if (r !== er) begin errors++;
        $display("FAIL dir%0d op=%b result: got %h expected %h", i, ops[i], r, er); end
      checks++; if ({ov, os, oz} !== {ev, es, ez}) begin errors++;
        $display("FAIL dir%0d op=%b v/set/zero: got %b expected %b", i, ops[i], {ov, os, oz},
                 {ev, es, ez}); end
      checks++; if (lat !== el) begin errors++;
        $display("FAIL dir%0d op=%b latency: got %0d expected %0d", i, ops[i], lat, el); end
    end
  endtask

  task automatic test_random();
    logic [3:0]  ops[12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                             4'b1000, 4'b1001, 4'b1010, 4'b1110, 4'b1111};
    logic [3:0]  op;
    logic [31:0] aa, bb, r, er;
    logic ov, os, oz, ev, es, ez;
    int lat, el;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 11)];
      aa = $urandom;
      bb = $urandom;
      case ($urandom_range(0, 3))
        0: bb = aa;
        1: bb = 32'($urandom_range(0, 3));
        2: aa = aa ^ 32'h8000_0000;
        default: ;
      endcase
      model(op, aa, bb, er, ev, es, ez, el);
      run_op(op, aa, bb, r, ov, os, oz, lat);
      checks++; if (r !== er) begin errors++;
        $display("FAIL rnd%0d op=%b a=%h b=%h result: got %h expected %h", i, op, aa, bb, r, er); end
      checks++; if ({ov, os, oz} !== {ev, es, ez}) begin errors++;
        $display("FAIL rnd%0d op=%b a=%h b=%h v/set/zero: got %b expected %b", i, op, aa, bb,
                 {ov, os, oz}, {ev, es, ez}); end
      checks++; if (lat !== el) begin errors++;
        $display("FAIL rnd%0d op=%b latency: got %0d expected %0d", i, op, lat, el); end
    end
  endtask

  // start held high: one accept per op; operands changed while busy are ignored.
  task automatic test_start_held();
    int dones = 0;
    int lat = 0;
    logic [31:0] first_res = '0;
    @(negedge clk);
    while (busy) @(negedge clk);
    alu_op = 4'b0010; a = 32'd10; b = 32'd20; start = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 33; e++) begin
      @(posedge clk);
      #1;
      if (e == 16) begin a = 32'd100; b = 32'd200; end
      if (done) begin dones++; first_res = result; end
      if (e == 32) begin
        checks++; if (done !== 1'b1) begin errors++;
          $display("FAIL held done@E32: got %b expected 1", done); end
      end
    end
    checks++; if (dones !== 1) begin errors++;
      $display("FAIL held done pulses: got %0d expected 1", dones); end
    checks++; if (first_res !== 32'd30) begin errors++;
      $display("FAIL held first result: got %h expected %h", first_res, 32'd30); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL held busy after E33: got %b expected 0", busy); end
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL held re-accept at E34: got busy %b expected 1", busy); end
    while (!done && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++; if (lat !== 32) begin errors++;
      $display("FAIL held second latency: got %0d expected 32", lat); end
    checks++; if (result !== 32'd300) begin errors++;
      $display("FAIL held second result: got %h expected %h", result, 32'd300); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r, er;
    logic ov, os, oz, ev, es, ez;
    int lat, el;
    run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, r, ov, os, oz, lat);
    @(negedge clk);
    while (busy) @(negedge clk);
    alu_op = 4'b0010; a = 32'h1234_5678; b = 32'h1111_1111; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, v, set, zero} !== 5'b0) begin errors++;
      $display("FAIL midreset busy/done/v/set/zero: got %b expected 00000",
               {busy, done, v, set, zero}); end
    checks++; if (result !== 32'h0) begin errors++;
      $display("FAIL midreset result: got %h expected 0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    model(4'b0010, 32'h7FFF_FFFF, 32'd1, er, ev, es, ez, el);
    run_op(4'b0010, 32'h7FFF_FFFF, 32'd1, r, ov, os, oz, lat);
    checks++; if (r !== er) begin errors++;
      $display("FAIL postreset result: got %h expected %h", r, er); end
    checks++; if ({ov, os, oz} !== {ev, es, ez}) begin errors++;
      $display("FAIL postreset v/set/zero: got %b expected %b", {ov, os, oz}, {ev, es, ez}); end
    checks++; if (lat !== el) begin errors++;
      $display("FAIL postreset latency: got %0d expected %0d", lat, el); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
